// File: rtl/dram_line_cache_if.sv
// Single-word request/response bus shared by the OS side and the DRAM bridge
// side of dram_line_cache.
//   master : drives in_valid (1-cycle pulse), addr, r_wb (1=read), data_w;
//            receives out_valid (1-cycle completion pulse) and data_r.
//   slave  : the opposite direction.
interface dram_line_cache_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [ADDR_W-1:0] addr;
    logic              r_wb;
    logic [DATA_W-1:0] data_w;
    logic              out_valid;
    logic [DATA_W-1:0] data_r;

    modport master (
        output in_valid, addr, r_wb, data_w,
        input  out_valid, data_r
    );

    modport slave (
        input  in_valid, addr, r_wb, data_w,
        output out_valid, data_r
    );
endinterface

// File: rtl/dram_line_cache.sv
// Direct-mapped, write-through, write-allocate single-word cache between the
// OS controller and the DRAM bridge.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   os_flush : one-cycle pulse, invalidates every line (honoured in IDLE only)
//   os_bus   : OS-side request bus (slave); read hits answer one cycle later
//   c_bus    : bridge-side bus (master); read misses and all writes go here
// hit_cnt is a saturating read-hit counter kept for hierarchical inspection.
module dram_line_cache #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              os_flush,
    dram_line_cache_if.slave  os_bus,
    dram_line_cache_if.master c_bus
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        HIT_RESP,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              r_wb_q,    r_wb_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] resp_q,    resp_d;
    logic [LINES-1:0]  valid_q,   valid_d;
    logic [15:0]       hit_cnt,   hit_cnt_d;

    logic [DATA_W-1:0] data_ram [LINES];
    logic [TAG_W-1:0]  tag_ram  [LINES];

    logic              fill_en;
    logic [DATA_W-1:0] fill_data;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req_hit;
    logic [IDX_W-1:0]  lat_idx;

    logic              os_out_valid;
    logic [DATA_W-1:0] os_data_r;
    logic              c_in_valid;
    logic [ADDR_W-1:0] c_addr;
    logic              c_r_wb;
    logic [DATA_W-1:0] c_data_w;

    assign req_idx = os_bus.addr[IDX_W-1:0];
    assign req_tag = os_bus.addr[ADDR_W-1:IDX_W];
    assign req_hit = valid_q[req_idx] && (tag_ram[req_idx] == req_tag);
    assign lat_idx = addr_q[IDX_W-1:0];

    assign os_bus.out_valid = os_out_valid;
    assign os_bus.data_r    = os_data_r;
    assign c_bus.in_valid   = c_in_valid;
    assign c_bus.addr       = c_addr;
    assign c_bus.r_wb       = c_r_wb;
    assign c_bus.data_w     = c_data_w;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        r_wb_d       = r_wb_q;
        wdata_d      = wdata_q;
        resp_d       = resp_q;
        valid_d      = valid_q;
        hit_cnt_d    = hit_cnt;
        fill_en      = 1'b0;
        fill_data    = '0;
        os_out_valid = 1'b0;
        os_data_r    = '0;
        c_in_valid   = 1'b0;
        c_addr       = '0;
        c_r_wb       = 1'b0;
        c_data_w     = '0;

        unique case (state_q)
            IDLE: begin
                if (os_flush) begin
                    valid_d   = '0;
                    hit_cnt_d = '0;
                end
                if (os_bus.in_valid) begin
                    addr_d  = os_bus.addr;
                    r_wb_d  = os_bus.r_wb;
                    wdata_d = os_bus.data_w;
                    if (!os_bus.r_wb) begin
                        state_d = WR_ISSUE;
                    end else if (req_hit && !os_flush) begin
                        // The line cannot change before HIT_RESP, so the hit
                        // data is captured now and replayed from resp_q.
                        state_d = HIT_RESP;
                        resp_d  = data_ram[req_idx];
                        if (hit_cnt != '1) begin
                            hit_cnt_d = hit_cnt + 16'd1;
                        end
                    end else begin
                        // A same-cycle flush invalidates first, so this misses.
                        state_d = RD_ISSUE;
                    end
                end
            end
            HIT_RESP, RESP: begin
                os_out_valid = 1'b1;
                os_data_r    = resp_q;
                state_d      = IDLE;
            end
            RD_ISSUE: begin
                c_in_valid = 1'b1;
                c_r_wb     = 1'b1;
                c_addr     = addr_q;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (c_bus.out_valid) begin
                    fill_en          = 1'b1;
                    fill_data        = c_bus.data_r;
                    resp_d           = c_bus.data_r;
                    valid_d[lat_idx] = 1'b1;
                    state_d          = RESP;
                end
            end
            WR_ISSUE: begin
                c_in_valid = 1'b1;
                c_addr     = addr_q;
                c_data_w   = wdata_q;
                state_d    = WR_WAIT;
            end
            WR_WAIT: begin
                // Line is allocated only once the bridge confirms the write.
                if (c_bus.out_valid) begin
                    fill_en          = 1'b1;
                    fill_data        = wdata_q;
                    resp_d           = '0;
                    valid_d[lat_idx] = 1'b1;
                    state_d          = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            r_wb_q  <= 1'b0;
            wdata_q <= '0;
            resp_q  <= '0;
            valid_q <= '0;
            hit_cnt <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            r_wb_q  <= r_wb_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            valid_q <= valid_d;
            hit_cnt <= hit_cnt_d;
        end
    end

    // Tag/data storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_ram[lat_idx] <= fill_data;
            tag_ram[lat_idx]  <= addr_q[ADDR_W-1:IDX_W];
        end
    end

endmodule

// File: tb/tb_dram_line_cache.sv
module tb_dram_line_cache;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 3;

    typedef struct {
        logic [7:0]  addr;
        logic        rwb;
        logic [63:0] data;
    } br_t;

    typedef struct {
        logic [63:0] data;
        int          lat;
    } resp_t;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic os_flush = 1'b0;

    dram_line_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) os_bus ();
    dram_line_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c_bus ();

    dram_line_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .os_flush (os_flush),
        .os_bus   (os_bus),
        .c_bus    (c_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    br_t   br_q[$];
    resp_t resp_q[$];

    // Reference cache model
    bit          m_valid [8];
    logic [4:0]  m_tag   [8];
    logic [63:0] m_data  [8];
    int          m_hits = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        os_bus.in_valid = 1'b0;
        os_bus.addr     = '0;
        os_bus.r_wb     = 1'b0;
        os_bus.data_w   = '0;
        os_flush        = 1'b0;
        c_bus.out_valid = 1'b0;
        c_bus.data_r    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hits = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " os_out_valid"}, 64'(os_bus.out_valid), 64'd0);
        check({tag, " os_data_r"},    os_bus.data_r,         64'd0);
        check({tag, " C_in/rwb/addr"}, 64'({c_bus.in_valid, c_bus.r_wb, c_bus.addr}), 64'd0);
        check({tag, " C_data_w"},     c_bus.data_w,          64'd0);
    endtask

    // One OS transaction; this task also plays the bridge with latency lat.
    task automatic os_req(input logic [7:0] a, input logic rwb, input logic [63:0] wd,
                          input logic [63:0] br_rd, input int lat,
                          input bit with_flush, input bit intrude);
        int          idx;
        logic [4:0]  tg;
        bit          hit;
        bit          got;
        int          n;
        int          fire_at;
        int          cin;
        br_t         b;
        resp_t       r;
        idx = int'(a[2:0]);
        tg  = a[7:3];
        if (with_flush) model_clear();
        hit = rwb && m_valid[idx] && (m_tag[idx] == tg);
        if (hit) begin
            r.data = m_data[idx];
            r.lat  = 1;
            if (m_hits < 65535) m_hits++;
        end else begin
            r.data = rwb ? br_rd : 64'd0;
            r.lat  = 2 + lat;
            b.addr = a;
            b.rwb  = rwb;
            b.data = rwb ? 64'd0 : wd;
            br_q.push_back(b);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = rwb ? br_rd : wd;
        end
        resp_q.push_back(r);

        os_bus.in_valid = 1'b1;
        os_bus.addr     = a;
        os_bus.r_wb     = rwb;
        os_bus.data_w   = wd;
        os_flush        = with_flush;

        n = 0; got = 0; fire_at = -1; cin = 0;
        while (!got && n < 40) begin
            tick();
            n++;
            clear_inputs();
            if (intrude && n == 2) begin
                os_bus.in_valid = 1'b1;
                os_bus.addr     = 8'hFF;
                os_bus.r_wb     = 1'b0;
                os_bus.data_w   = 64'hBAD0;
                os_flush        = 1'b1;
            end
            if (c_bus.in_valid) begin
                cin++;
                check("bridge request expected", 64'(br_q.size() != 0), 64'd1);
                if (br_q.size() != 0) begin
                    b = br_q.pop_front();
                    check("C_addr", 64'(c_bus.addr), 64'(b.addr));
                    check("C_r_wb", 64'(c_bus.r_wb), 64'(b.rwb));
                    check("C_data_w", c_bus.data_w, b.data);
                end
                fire_at = n + lat;
            end
            if (n == fire_at) begin
                c_bus.out_valid = 1'b1;
                c_bus.data_r    = br_rd;
            end
            if (os_bus.out_valid) begin
                got = 1;
                check("response expected", 64'(resp_q.size() != 0), 64'd1);
                if (resp_q.size() != 0) begin
                    r = resp_q.pop_front();
                    check("os_data_r", os_bus.data_r, r.data);
                    check("latency", 64'(n), 64'(r.lat));
                end
            end
        end
        check("response seen", 64'(got), 64'd1);
        check("bridge request count", 64'(cin), hit ? 64'd0 : 64'd1);
        clear_inputs();
        tick();
        check_idle("after resp");
        tick();
        check("no queued request", 64'(c_bus.in_valid), 64'd0);
    endtask

    initial begin
        clear_inputs();
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("hit_cnt reset", 64'(dut.hit_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Cold read, hit, write-through, hit on written data
        os_req(8'h12, 1'b1, 64'd0, 64'hDEAD_BEEF_0000_0012, 3, 0, 0);
        os_req(8'h12, 1'b1, 64'd0, 64'd0, 1, 0, 0);
        check("hit_cnt after hit", 64'(dut.hit_cnt), 64'(m_hits));
        os_req(8'h12, 1'b0, 64'h1, 64'hFFFF, 2, 0, 0);
        os_req(8'h12, 1'b1, 64'd0, 64'd0, 1, 0, 0);
        check("hit_cnt two hits", 64'(dut.hit_cnt), 64'(m_hits));

        // Conflict on index 2: 8'h1A evicts 8'h12
        os_req(8'h1A, 1'b1, 64'd0, 64'hA1A1_0000_0000_001A, 1, 0, 0);
        os_req(8'h12, 1'b1, 64'd0, 64'h1, 2, 0, 0);

        // Flush, then a previously cached line misses
        os_flush = 1'b1;
        tick();
        os_flush = 1'b0;
        model_clear();
        check("hit_cnt after flush", 64'(dut.hit_cnt), 64'd0);
        os_req(8'h1A, 1'b1, 64'd0, 64'h0000_1A1A_1A1A_0001, 1, 0, 0);
        os_req(8'h1A, 1'b1, 64'd0, 64'd0, 1, 0, 0);

        // Write-allocate on a cold line, then hit
        os_req(8'h05, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 3, 0, 0);
        os_req(8'h05, 1'b1, 64'd0, 64'd0, 1, 0, 0);

        // Flush in the same cycle as a read of a cached line: must miss
        os_req(8'h05, 1'b1, 64'd0, 64'h5555_5555_5555_5555, 2, 1, 0);
        check("hit_cnt flush+req", 64'(dut.hit_cnt), 64'(m_hits));

        // Request and flush arriving during RD_WAIT are ignored
        os_req(8'h27, 1'b1, 64'd0, 64'h2727_2727_0000_0000, 4, 0, 1);
        os_req(8'h05, 1'b1, 64'd0, 64'd0, 1, 0, 0);

        // Stray C_out_valid in IDLE
        c_bus.out_valid = 1'b1;
        c_bus.data_r    = 64'hBAD_BAD;
        tick();
        clear_inputs();
        check_idle("stray C_out_valid");
        os_req(8'h1A, 1'b1, 64'd0, 64'd0, 1, 0, 0);
        check("hit_cnt before reset", 64'(dut.hit_cnt), 64'(m_hits));

        // Reset while waiting on a write
        os_bus.in_valid = 1'b1;
        os_bus.addr     = 8'h33;
        os_bus.r_wb     = 1'b0;
        os_bus.data_w   = 64'h3333;
        tick();
        clear_inputs();
        check("wr C_in_valid", 64'(c_bus.in_valid), 64'd1);
        check("wr C_r_wb", 64'(c_bus.r_wb), 64'd0);
        check("wr C_addr", 64'(c_bus.addr), 64'h33);
        check("wr C_data_w", c_bus.data_w, 64'h3333);
        tick();
        check("wr waiting", 64'(c_bus.in_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check_idle("reset in WR_WAIT");
        check("hit_cnt reset mid", 64'(dut.hit_cnt), 64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Late bridge completion after reset
        c_bus.out_valid = 1'b1;
        c_bus.data_r    = 64'h3333;
        tick();
        clear_inputs();
        check_idle("late C_out_valid");
        os_req(8'h33, 1'b1, 64'd0, 64'h0000_0000_0033_0033, 1, 0, 0);
        os_req(8'h1A, 1'b1, 64'd0, 64'h1A00, 2, 0, 0);

        check("scoreboard drained", 64'(br_q.size() + resp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
